alu_seq_control: RTL and testbench
==================================

# alu_seq_control

Parametrised successor to the combinational ALU control decoder for the pipeline's EX stage. It decodes ALUOp/funct into an operation code and also executes the operation. Single-cycle ops complete in one cycle; the unsigned multiply and divide run as W-cycle iterative operations under a valid/ready handshake. The hazard unit uses `busy` to stall ID/EX while a multi-cycle op is in flight.

## Interface
- `W`, default 32: operand/result width; must be ≥ 4.
- `ENABLE_MDU`, default 1: 1 enables MUL/DIVU; 0 decodes them as illegal.
- `clk`, input, 1: the only clock; rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `in_valid`, input, 1: an op is presented.
- `in_ready`, output, 1: block can accept; high when state ≠ BUSY.
- `ALUOp`, input, 2: main-decoder op class.
- `F`, input, 6: funct field.
- `A`, `B`, input, W: operands (B is already the immediate for LW/SW/ORI).
- `flush`, input, 1: abort the in-flight op.
- `Operation`, output, 4: registered op code of the last accepted op.
- `out_valid`, output, 1: one-cycle result strobe.
- `result`, output, W: primary result.
- `hi`, output, W: MUL high half or DIVU remainder; 0 for other ops.
- `illegal`, output, 1: qualifies `out_valid` for an undecodable op.
- `busy`, output, 1: high while state = BUSY.

## Operation
- Decode and op codes:
  - ALUOp 00 → ADD 0010.
  - ALUOp 01 → SUB 0110.
  - ALUOp 11 → OR 0001.
  - ALUOp 10, by F:
    - 000010 → ADD 0010.
    - 000000 → XOR 0000.
    - 000100 → AND 0011.
    - 000101 → OR 0001.
    - 000110 → SUB 0110.
    - 000111 → SLT 0111.
    - 011000 → MUL 1000.
    - 011010 → DIVU 1001.
    - Any other F → illegal 1111.
- States: IDLE, BUSY, DONE.
- Accept: acceptance occurs when `in_valid` and `in_ready` are both high at a clock edge.
  - Single-cycle op or illegal op → DONE, with result, hi and illegal registered at that edge.
  - MUL or DIVU → BUSY, operands latched, counter loaded with W.
- BUSY: one iteration per edge; the counter decrements. The edge that brings the counter from 1 to 0 writes the final result and moves to DONE.
- DONE: `out_valid` is high for this cycle only.
  - A new acceptance in DONE behaves exactly as in IDLE, so back-to-back single-cycle ops run at one per cycle.
  - Otherwise DONE → IDLE.
- No output backpressure. The consumer must take the result in the `out_valid` cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^W.
  - SLT is signed and yields 0 or 1.
  - MUL is unsigned shift-add: `result` = low W bits of A*B, `hi` = high W bits.
  - DIVU is restoring unsigned division: `result` = quotient, `hi` = remainder.
  - DIVU with B = 0: quotient = all ones, remainder = A, same latency.
- Illegal op: `result` = 0, `hi` = 0, `illegal` = 1, delivered with `out_valid`.
- `flush`:
  - Forces IDLE at the next edge and suppresses any `out_valid` for the aborted op.
  - Takes priority over acceptance in the same cycle.
  - Does not clear `Operation`.
- `reset`: every output except `in_ready` = 0, state = IDLE, counter = 0. `in_ready` = 1.

## Timing
- Acceptance edge E.
- Single-cycle op: `out_valid` high from E to E+1 (latency 1).
- MUL/DIVU:
  - `busy` and `in_ready` low from E to E+W.
  - `out_valid` high from E+W to E+W+1 (latency W).
  - `in_ready` returns high at E+W.
- `in_ready` is combinational from state only, never from `in_valid`.
- `reset` asserted mid-BUSY clears state immediately and produces no `out_valid`.
- `flush` and the final iteration edge in the same cycle: flush wins and no `out_valid` is produced.

## Test plan
- W=8, ADD: A=0xF0, B=0x20, ALUOp=10, F=000010 → Operation=0010, result=0x10 after 1 cycle; also checks wrap.
- Single-cycle throughput: XOR, ORI, SLT issued on consecutive cycles; SLT with A=0x80, B=0x01 → results 0x.., 0x.., 1; `out_valid` high 3 consecutive cycles; `in_ready` never low.
- W=8, MUL: A=0x0F, B=0x11 → `busy` high 8 cycles; result=0xFF, hi=0x00; a second op offered during BUSY is not accepted until `in_ready` rises.
- W=8, DIVU: A=100, B=7 → quotient 14, remainder 2. Then B=0 → result=0xFF, hi=100.
- Illegal: ALUOp=10, F=111111 → Operation=1111, `illegal`=1, result=0. With ENABLE_MDU=0, F=011000 → `illegal`=1 after 1 cycle.
- Abort: `flush` at cycle 3 of a MUL, then `reset` at cycle 3 of a DIVU → no `out_valid` in either case; state IDLE; all outputs return to reset values.

Source files
------------

// File: rtl/alu_seq_control.sv
// -----------------------------------------------------------------------------
// alu_seq_control
//
// EX-stage ALU control decoder that also executes the decoded operation.
// ADD/SUB/AND/OR/XOR/SLT finish in one cycle. The unsigned MUL (shift-add)
// and DIVU (restoring division) take W iterations behind a valid/ready
// handshake. The hazard unit stalls ID/EX on `busy`.
//
// Parameters
//   W           operand/result width (>= 4)
//   ENABLE_MDU  1: MUL/DIVU implemented, 0: they decode as illegal
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   in_valid   an op is presented on ALUOp/F/A/B
//   in_ready   block can accept (state is not BUSY)
//   ALUOp      main-decoder op class
//   F          funct field
//   A, B       operands (B already holds the immediate for LW/SW/ORI)
//   flush      abort the in-flight op; beats acceptance in the same cycle
//   Operation  op code of the last accepted op
//   out_valid  one-cycle result strobe
//   result     primary result (MUL low half / DIVU quotient)
//   hi         MUL high half / DIVU remainder, 0 for other ops
//   illegal    qualifies out_valid for an undecodable op
//   busy       a multi-cycle op is in flight
// -----------------------------------------------------------------------------
module alu_seq_control #(
  parameter int W          = 32,
  parameter int ENABLE_MDU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   ALUOp,
  input  logic [5:0]   F,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         flush,
  output logic [3:0]   Operation,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic [W-1:0] hi,
  output logic         illegal,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_XOR  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1001,
    OP_ILL  = 4'b1111
  } op_e;

  state_e         state, state_nx;
  op_e            dec_op;
  logic           dec_multi;
  logic           accept;
  logic [W-1:0]   single_res;

  // Iterative datapath: opnd holds the multiplicand (MUL) or divisor (DIVU);
  // work_lo holds the multiplier / dividend being shifted out while the
  // quotient or low product shifts in; work_hi is the high product / partial
  // remainder.
  logic [CW-1:0]  cnt;
  logic [W-1:0]   opnd;
  logic [W-1:0]   work_hi;
  logic [W-1:0]   work_lo;
  logic [W-1:0]   iter_hi;
  logic [W-1:0]   iter_lo;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shifted;
  logic           div_ge;
  logic [W-1:0]   div_diff;

  // Handshake/status come from the state alone so in_ready never depends on
  // in_valid.
  assign in_ready  = (state != BUSY);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  // flush beats acceptance.
  assign accept = in_valid && in_ready && !flush;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can leave it unassigned and infer a latch.
    dec_op = OP_ILL;
    unique case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b11: dec_op = OP_OR;
      2'b10: begin
        case (F)
          6'b000010: dec_op = OP_ADD;
          6'b000000: dec_op = OP_XOR;
          6'b000100: dec_op = OP_AND;
          6'b000101: dec_op = OP_OR;
          6'b000110: dec_op = OP_SUB;
          6'b000111: dec_op = OP_SLT;
          6'b011000: dec_op = (ENABLE_MDU != 0) ? OP_MUL  : OP_ILL;
          6'b011010: dec_op = (ENABLE_MDU != 0) ? OP_DIVU : OP_ILL;
          default:   dec_op = OP_ILL;
        endcase
      end
      default: dec_op = OP_ILL;
    endcase
  end

  assign dec_multi = (dec_op == OP_MUL) || (dec_op == OP_DIVU);

  // ---------------------------------------------------------------------------
  // Single-cycle execution
  // ---------------------------------------------------------------------------
  always_comb begin
    single_res = '0;
    case (dec_op)
      OP_ADD: single_res = A + B;
      OP_SUB: single_res = A - B;
      OP_AND: single_res = A & B;
      OP_OR:  single_res = A | B;
      OP_XOR: single_res = A ^ B;
      OP_SLT: single_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      default: single_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One MUL / DIVU iteration
  // ---------------------------------------------------------------------------
  // Shift-add: add the multiplicand when the current multiplier bit is set,
  // then shift the (W+1)-bit sum right into the product pair.
  assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});

  // Restoring division: bring the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. A zero divisor always
  // "fits", yielding an all-ones quotient with remainder = dividend.
  assign div_shifted = {work_hi, work_lo[W-1]};
  assign div_ge      = (div_shifted >= {1'b0, opnd});
  // The true difference is below the divisor whenever it is taken, so W bits
  // are enough.
  assign div_diff    = div_shifted[W-1:0] - opnd;

  always_comb begin
    iter_hi = work_hi;
    iter_lo = work_lo;
    if (Operation == OP_DIVU) begin
      iter_hi = div_ge ? div_diff : div_shifted[W-1:0];
      iter_lo = {work_lo[W-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[W:1];
      iter_lo = {mul_sum[0], work_lo[W-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample their inputs from before the edge, independent of
    // statement order.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)              state_nx = dec_multi ? BUSY : DONE;
        else                     state_nx = IDLE;
      end
      BUSY: begin
        if (cnt == CW'(1))       state_nx = DONE;
      end
      default:                   state_nx = IDLE;
    endcase
    // An aborted op never reaches DONE, so it never strobes out_valid.
    if (flush) state_nx = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Operation <= '0;
      result    <= '0;
      hi        <= '0;
      illegal   <= 1'b0;
      cnt       <= '0;
      opnd      <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
    end else if (flush) begin
      // Operation is deliberately kept so the pipeline can see what was aborted.
      result    <= '0;
      hi        <= '0;
      illegal   <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      Operation <= dec_op;
      if (dec_multi) begin
        cnt     <= CW'(W);
        work_hi <= '0;
        if (dec_op == OP_MUL) begin
          opnd    <= A;
          work_lo <= B;
        end else begin
          opnd    <= B;
          work_lo <= A;
        end
      end else begin
        result  <= single_res;
        hi      <= '0;
        illegal <= (dec_op == OP_ILL);
      end
    end else if (state == BUSY) begin
      cnt     <= cnt - CW'(1);
      work_hi <= iter_hi;
      work_lo <= iter_lo;
      if (cnt == CW'(1)) begin
        result  <= iter_lo;
        hi      <= iter_hi;
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_control.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_control
//
// Self-checking bench for alu_seq_control at W=8. A main instance has the
// MUL/DIVU unit enabled; a second instance with it disabled shares the inputs
// and is checked only for MUL decoding as illegal. Expected values come from
// a behavioural model using plain arithmetic (*, /, %, signed compare).
// -----------------------------------------------------------------------------
module tb_alu_seq_control;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   ALUOp;
  logic [5:0]   F;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         flush;
  logic [3:0]   Operation;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         illegal;
  logic         busy;

  logic         in_ready_n;
  logic [3:0]   Operation_n;
  logic         out_valid_n;
  logic [W-1:0] result_n;
  logic [W-1:0] hi_n;
  logic         illegal_n;
  logic         busy_n;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_control #(.W(W), .ENABLE_MDU(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .F(F), .A(A), .B(B), .flush(flush),
    .Operation(Operation), .out_valid(out_valid), .result(result),
    .hi(hi), .illegal(illegal), .busy(busy)
  );

  alu_seq_control #(.W(W), .ENABLE_MDU(0)) dut_nomdu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
    .ALUOp(ALUOp), .F(F), .A(A), .B(B), .flush(flush),
    .Operation(Operation_n), .out_valid(out_valid_n), .result(result_n),
    .hi(hi_n), .illegal(illegal_n), .busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected outcome of one op; `extra` is the number of edges after the
  // acceptance edge before out_valid is seen (0 single-cycle, W for MUL/DIVU).
  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ill;
    int           extra;
  } exp_t;

  function automatic exp_t model(input logic [1:0] aluop, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit mdu);
    exp_t e;
    int unsigned ua, ub, prod;
    ua = a;
    ub = b;
    e.op = 4'b1111; e.res = '0; e.hi = '0; e.ill = 1'b1; e.extra = 0;
    if (aluop == 2'b00)      begin e.op = 4'b0010; e.res = W'((ua + ub) % 256); e.ill = 0; end
    else if (aluop == 2'b01) begin e.op = 4'b0110; e.res = W'((ua + 256 - ub) % 256); e.ill = 0; end
    else if (aluop == 2'b11) begin e.op = 4'b0001; e.res = a | b; e.ill = 0; end
    else begin
      case (f)
        6'b000010: begin e.op = 4'b0010; e.res = W'((ua + ub) % 256); e.ill = 0; end
        6'b000000: begin e.op = 4'b0000; e.res = a ^ b; e.ill = 0; end
        6'b000100: begin e.op = 4'b0011; e.res = a & b; e.ill = 0; end
        6'b000101: begin e.op = 4'b0001; e.res = a | b; e.ill = 0; end
        6'b000110: begin e.op = 4'b0110; e.res = W'((ua + 256 - ub) % 256); e.ill = 0; end
        6'b000111: begin e.op = 4'b0111; e.res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0; e.ill = 0; end
        6'b011000: if (mdu) begin
          prod = ua * ub;
          e.op = 4'b1000; e.res = W'(prod % 256); e.hi = W'(prod / 256); e.ill = 0; e.extra = W;
        end
        6'b011010: if (mdu) begin
          e.op = 4'b1001; e.ill = 0; e.extra = W;
          if (ub == 0) begin e.res = 8'hFF; e.hi = a; end
          else begin e.res = W'(ua / ub); e.hi = W'(ua % ub); end
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op from an idle block, wait (bounded) for its strobe and
  // compare everything against the model.
  task automatic run_op(input string tag, input logic [1:0] aluop, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   edges;
    int   busy_cycles;
    e = model(aluop, f, a, b, 1'b1);
    check({tag, "_ready_before"}, in_ready, 1);
    ALUOp = aluop; F = f; A = a; B = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_op"}, Operation, e.op);
    edges = 0;
    busy_cycles = 0;
    while (!out_valid && edges < 4 * W) begin
      if (busy && !in_ready) busy_cycles++;
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, e.extra);
    check({tag, "_busy_cycles"}, busy_cycles, e.extra);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, e.res);
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_illegal"}, illegal, e.ill);
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic no_valid_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check({tag, "_no_valid"}, seen, 0);
  endtask

  initial begin : stim
    exp_t e;
    int   busy_cycles;
    int   edges;
    logic op_held;
    logic [1:0] aluop;
    logic [5:0] f;
    logic [5:0] f_tab [9];
    logic [W-1:0] a, b;

    f_tab[0] = 6'b000010; f_tab[1] = 6'b000000; f_tab[2] = 6'b000100;
    f_tab[3] = 6'b000101; f_tab[4] = 6'b000110; f_tab[5] = 6'b000111;
    f_tab[6] = 6'b011000; f_tab[7] = 6'b011010; f_tab[8] = 6'b111111;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    ALUOp = '0; F = '0; A = '0; B = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_outs", {Operation, out_valid, result, hi, illegal, busy}, '0);
    tick();
    reset = 1'b0;
    tick();

    // ADD with wrap: 0xF0 + 0x20 = 0x110 -> 0x10
    run_op("add_wrap", 2'b10, 6'b000010, 8'hF0, 8'h20);

    // Back-to-back single-cycle ops: XOR, ORI, SLT
    ALUOp = 2'b10; F = 6'b000000; A = 8'h5A; B = 8'h0F; in_valid = 1'b1;
    tick();
    check("tp_xor_valid", out_valid, 1);
    check("tp_xor_res", result, 8'h55);
    check("tp_xor_ready", in_ready, 1);
    ALUOp = 2'b11; A = 8'h30; B = 8'h05;
    tick();
    check("tp_ori_valid", out_valid, 1);
    check("tp_ori_res", result, 8'h35);
    check("tp_ori_ready", in_ready, 1);
    ALUOp = 2'b10; F = 6'b000111; A = 8'h80; B = 8'h01;
    tick();
    check("tp_slt_valid", out_valid, 1);
    check("tp_slt_res", result, 8'h01);
    check("tp_slt_op", Operation, 4'b0111);
    check("tp_slt_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    check("tp_drop", out_valid, 0);

    // MUL 0x0F * 0x11 = 0x00FF with an ADD held on the inputs throughout
    ALUOp = 2'b10; F = 6'b011000; A = 8'h0F; B = 8'h11; in_valid = 1'b1;
    tick();
    ALUOp = 2'b00; A = 8'h03; B = 8'h04;
    busy_cycles = 0;
    edges = 0;
    op_held = 1'b1;
    while (!out_valid && edges < 4 * W) begin
      if (busy) busy_cycles++;
      if (Operation != 4'b1000) op_held = 1'b0;
      tick();
      edges++;
    end
    check("mul_busy_cycles", busy_cycles, W);
    check("mul_op_held", op_held, 1);
    check("mul_result", result, 8'hFF);
    check("mul_hi", hi, 8'h00);
    check("mul_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("held_add_valid", out_valid, 1);
    check("held_add_op", Operation, 4'b0010);
    check("held_add_res", result, 8'h07);
    tick();

    // DIVU
    run_op("divu", 2'b10, 6'b011010, 8'd100, 8'd7);
    run_op("divu_by0", 2'b10, 6'b011010, 8'd100, 8'd0);

    // Illegal funct
    run_op("ill_f", 2'b10, 6'b111111, 8'h12, 8'h34);

    // MUL on the MDU-less instance decodes as illegal in one cycle
    ALUOp = 2'b10; F = 6'b011000; A = 8'h03; B = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("nomdu_valid", out_valid_n, 1);
    check("nomdu_illegal", illegal_n, 1);
    check("nomdu_op", Operation_n, 4'b1111);
    check("nomdu_result", result_n, 0);
    check("nomdu_busy", busy_n, 0);
    edges = 0;
    while (!out_valid && edges < 4 * W) begin tick(); edges++; end
    check("nomdu_main_mul", result, 8'd15);
    tick();

    // flush in the third cycle of a MUL
    ALUOp = 2'b10; F = 6'b011000; A = 8'h21; B = 8'h43; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_ready", in_ready, 1);
    check("flush_op_kept", Operation, 4'b1000);
    no_valid_for("flush_mid", W + 2);

    // flush on the final iteration edge
    ALUOp = 2'b10; F = 6'b011000; A = 8'hFF; B = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W - 1; i++) tick();
    check("flush_last_still_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_last_busy", busy, 0);
    no_valid_for("flush_last", W + 2);

    // flush beats acceptance
    ALUOp = 2'b00; A = 8'h01; B = 8'h01; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_prio_valid", out_valid, 0);
    check("flush_prio_op", Operation, 4'b1000);
    tick();

    // asynchronous reset in the third cycle of a DIVU
    ALUOp = 2'b10; F = 6'b011010; A = 8'd200; B = 8'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_outs", {Operation, out_valid, result, hi, illegal, busy}, '0);
    tick();
    reset = 1'b0;
    no_valid_for("arst", W + 2);

    // Randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      aluop = 2'($urandom_range(0, 3));
      f = f_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) f = 6'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op("rand", aluop, f, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
